// File: rtl/elc3_control_fsm.sv
// elc3_control_fsm - Moore control unit sequencing the eLC-3 datapath through fetch, decode and execute.
// All control outputs are registered alongside the state; the wait counter times every SRAM access.
module elc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        LD_PC,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  PCMUX,
  output logic [1:0]  DRMUX,
  output logic [1:0]  SR1MUX,
  output logic [1:0]  MARMUX,
  output logic [1:0]  ALUK,
  output logic        MIO_EN,
  output logic        R_W,
  output logic        Halted,
  output logic        Paused,
  output logic        Illegal
);

  typedef enum logic [4:0] {
    S_HALTED, S_F1, S_F2, S_F3, S_DEC, S_ALU, S_LEA, S_BR0, S_JMP, S_J0, S_J1,
    S_ADDR, S_RD, S_IND, S_RD2, S_LDWB, S_STMDR, S_WR, S_PAUSE, S_PREL
  } state_t;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic       addr1mux;
    logic [1:0] addr2mux, pcmux, drmux, sr1mux, marmux, aluk;
    logic       mio_en, r_w, halted, paused;
  } ctrl_t;

  localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_LD = 4'b0010, OP_ST = 4'b0011,
                         OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                         OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_PAUSE = 4'b1101, OP_LEA = 4'b1110;

  state_t     state, nxt;
  ctrl_t      ctrl;
  logic [3:0] cnt;
  logic       run_q, set_illegal, mem_done, in_mem;
  logic [3:0] op;
  logic       unused_ir;

  assign op        = IR[15:12];
  assign unused_ir = ^IR[10:0];
  assign in_mem    = (state == S_F2) || (state == S_RD) || (state == S_RD2) || (state == S_WR);
  assign mem_done  = (cnt == 4'(MEM_WAIT - 1));

  function automatic ctrl_t ctrl_for(state_t s, logic [3:0] o, logic ir11);
    ctrl_t c;
    c = '0;
    case (s)
      S_HALTED: c.halted = 1'b1;
      S_F1:     begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; end
      S_F2, S_RD, S_RD2: begin c.mio_en = 1'b1; c.ld_mdr = 1'b1; end
      S_F3:     begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      S_DEC:    c.ld_ben = 1'b1;
      S_ALU: begin
        c.sr1mux = 2'b01; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.aluk   = (o == OP_AND) ? 2'b01 : (o == OP_NOT) ? 2'b10 : 2'b00;
      end
      S_LEA:    begin c.addr2mux = 2'b10; c.gate_marmux = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      S_BR0:    begin c.pcmux = 2'b10; c.addr2mux = 2'b10; c.ld_pc = 1'b1; end
      S_JMP:    begin c.sr1mux = 2'b01; c.addr1mux = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      S_J0:     begin c.gate_pc = 1'b1; c.drmux = 2'b01; c.ld_reg = 1'b1; end
      S_J1: begin
        c.pcmux = 2'b10; c.ld_pc = 1'b1;
        if (ir11) c.addr2mux = 2'b11;
        else begin c.sr1mux = 2'b01; c.addr1mux = 1'b1; end
      end
      S_ADDR: begin
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
        if (o == OP_LDR || o == OP_STR) begin
          c.addr1mux = 1'b1; c.sr1mux = 2'b01; c.addr2mux = 2'b01;
        end else c.addr2mux = 2'b10;
      end
      S_IND:    begin c.gate_mdr = 1'b1; c.ld_mar = 1'b1; end
      S_LDWB:   begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      S_STMDR:  begin c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
      S_WR:     begin c.mio_en = 1'b1; c.r_w = 1'b1; end
      S_PAUSE, S_PREL: c.paused = 1'b1;
      default:  c.halted = 1'b1;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt         = state;
    set_illegal = 1'b0;
    case (state)
      S_HALTED: if (Run) nxt = S_F1;
      S_F1:     nxt = Run ? S_F2 : S_HALTED;
      S_F2:     if (mem_done) nxt = S_F3;
      S_F3:     nxt = S_DEC;
      S_DEC: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT:                 nxt = S_ALU;
          OP_LEA:                                 nxt = S_LEA;
          OP_BR:                                  nxt = S_BR0;
          OP_JMP:                                 nxt = S_JMP;
          OP_JSR:                                 nxt = S_J0;
          OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: nxt = S_ADDR;
          OP_PAUSE:                               nxt = S_PAUSE;
          default: begin nxt = S_HALTED; set_illegal = 1'b1; end
        endcase
      end
      S_J0:     nxt = S_J1;
      S_ADDR:   nxt = (op == OP_ST || op == OP_STR) ? S_STMDR : S_RD;
      S_RD:     if (mem_done) nxt = (op == OP_LDI || op == OP_STI) ? S_IND : S_LDWB;
      S_IND:    nxt = (op == OP_LDI) ? S_RD2 : S_STMDR;
      S_RD2:    if (mem_done) nxt = S_LDWB;
      S_STMDR:  nxt = S_WR;
      S_WR:     if (mem_done) nxt = S_F1;
      S_PAUSE:  if (Continue) nxt = S_PREL;
      S_PREL:   if (!Continue) nxt = S_F1;
      S_ALU, S_LEA, S_BR0, S_JMP, S_J1, S_LDWB: nxt = S_F1;
      default:  nxt = S_HALTED;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_HALTED;
      ctrl    <= ctrl_for(S_HALTED, 4'h0, 1'b0);
      cnt     <= 4'd0;
      run_q   <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      state <= nxt;
      ctrl  <= ctrl_for(nxt, op, IR[11]);
      cnt   <= (in_mem && !mem_done) ? cnt + 4'd1 : 4'd0;
      run_q <= Run;
      if (set_illegal)       Illegal <= 1'b1;
      else if (Run && !run_q) Illegal <= 1'b0;
    end
  end

  assign LD_MAR     = ctrl.ld_mar;
  assign LD_MDR     = ctrl.ld_mdr;
  assign LD_IR      = ctrl.ld_ir;
  assign LD_BEN     = ctrl.ld_ben;
  assign LD_REG     = ctrl.ld_reg;
  assign LD_CC      = ctrl.ld_cc;
  // BEN is latched on the same edge that enters BR0, so the branch decision is applied here.
  assign LD_PC      = ctrl.ld_pc & (BEN | (state != S_BR0));
  assign GatePC     = ctrl.gate_pc;
  assign GateMDR    = ctrl.gate_mdr;
  assign GateALU    = ctrl.gate_alu;
  assign GateMARMUX = ctrl.gate_marmux;
  assign ADDR1MUX   = ctrl.addr1mux;
  assign ADDR2MUX   = ctrl.addr2mux;
  assign PCMUX      = ctrl.pcmux;
  assign DRMUX      = ctrl.drmux;
  assign SR1MUX     = ctrl.sr1mux;
  assign MARMUX     = ctrl.marmux;
  assign ALUK       = ctrl.aluk;
  assign MIO_EN     = ctrl.mio_en;
  assign R_W        = ctrl.r_w;
  assign Halted     = ctrl.halted;
  assign Paused     = ctrl.paused;

  bus_one_driver: assert property (@(posedge Clk) disable iff (!Reset)
    $onehot0({GatePC, GateMDR, GateALU, GateMARMUX}));

endmodule
